// File: rtl/alu_issuer_pkg.sv
// alu_issuer_pkg: shared definitions for the ALU issuer block.
//   - opcode constants OP_AND / OP_OR / OP_SUB / OP_ADD (2-bit)
//   - FSM state enum for the issuer sequencer
//   - operand width (4) and result width (5)
//   - cnt_width(): smallest settle-counter width (>= 1 bit) for a wait count
package alu_issuer_pkg;

  localparam int OPER_W = 4;
  localparam int RES_W  = 5;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_AND = 2'b00;
  localparam opcode_t OP_OR  = 2'b01;
  localparam opcode_t OP_SUB = 2'b10;
  localparam opcode_t OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Counter must hold the value n itself; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden result for one ALU operation.
// Ports:
//   code : opcode (AND, OR, SUB, ADD)
//   a, b : 4-bit operands
//   c    : expected 5-bit result. AND/OR zero-extended, SUB is
//          {0,a}-{0,b} modulo 32, ADD is the full 5-bit sum.
module alu_ref_model
  import alu_issuer_pkg::*;
(
  input  logic [1:0]        code,
  input  logic [OPER_W-1:0] a,
  input  logic [OPER_W-1:0] b,
  output logic [RES_W-1:0]  c
);

  // Select the expected result for the current opcode.
  always_comb begin
    c = 5'd0;
    case (code)
      OP_AND:  c = {1'b0, a & b};
      OP_OR:   c = {1'b0, a | b};
      OP_SUB:  c = {1'b0, a} - {1'b0, b};
      OP_ADD:  c = {1'b0, a} + {1'b0, b};
      default: c = 5'd0;
    endcase
  end

endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: issues one ALU operation (or a sweep of all four opcodes)
// per accepted request, waits SETTLE_CYC cycles for the external ALU to
// settle, captures alu_c and hands it downstream with valid/ready.
//
// Parameter: SETTLE_CYC (0..15) wait cycles between driving the operands
//            and capturing alu_c.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_code, req_a, req_b   : opcode and 4-bit operands
//   req_sweep                : issue 00,01,10,11 on one operand pair
//   alu_code, alu_a, alu_b   : drive to the external ALU
//   alu_c                    : 5-bit ALU result
//   rsp_valid/rsp_ready      : response handshake
//   rsp_code, rsp_c, rsp_last: issued opcode, captured result, final flag
//   busy                     : high whenever not IDLE
//   err                      : sticky result-mismatch flag
//
// Optional feature macro: ALU_ISSUER_RESULT_CHECK_EN
//   defined   : each capture is compared against alu_ref_model; a mismatch
//               sets err until reset.
//   undefined : no checker logic, err is tied to 0.
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_code,
  input  logic [OPER_W-1:0] req_a,
  input  logic [OPER_W-1:0] req_b,
  input  logic              req_sweep,
  output logic [1:0]        alu_code,
  output logic [OPER_W-1:0] alu_a,
  output logic [OPER_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic [RES_W-1:0]  rsp_c,
  output logic              rsp_last,
  output logic              busy,
  output logic              err
);

  localparam int             CNT_W    = cnt_width(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [1:0]          code_q,      code_d;
  logic [OPER_W-1:0]   a_q,         a_d;
  logic [OPER_W-1:0]   b_q,         b_d;
  logic                sweep_q,     sweep_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_code_q,  rsp_code_d;
  logic [RES_W-1:0]    rsp_c_q,     rsp_c_d;
  logic                rsp_last_q,  rsp_last_d;
  logic                busy_q,      busy_d;
  logic                req_ready_q, req_ready_d;

`ifdef ALU_ISSUER_RESULT_CHECK_EN
  logic                err_q,       err_d;
  logic [RES_W-1:0]    exp_c_s;

  alu_ref_model u_ref (
    .code (code_q),
    .a    (a_q),
    .b    (b_q),
    .c    (exp_c_s)
  );
`endif

  // Next-state and next-output computation for the issuer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    a_d         = a_q;
    b_d         = b_q;
    sweep_d     = sweep_q;
    rsp_valid_d = rsp_valid_q;
    rsp_code_d  = rsp_code_q;
    rsp_c_d     = rsp_c_q;
    rsp_last_d  = rsp_last_q;
`ifdef ALU_ISSUER_RESULT_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // req_ready_q is the registered ready seen by upstream; gating on it
        // keeps the accept consistent with what was advertised.
        if (req_valid && req_ready_q) begin
          a_d     = req_a;
          b_d     = req_b;
          sweep_d = req_sweep;
          code_d  = req_sweep ? OP_AND : req_code;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          rsp_c_d     = alu_c;
          rsp_code_d  = code_q;
          rsp_last_d  = (!sweep_q) || (code_q == OP_ADD);
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`ifdef ALU_ISSUER_RESULT_CHECK_EN
          if (alu_c != exp_c_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (sweep_q && (code_q != OP_ADD)) begin
            code_d  = code_q + 2'd1;
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      code_q      <= 2'b00;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      sweep_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'b00;
      rsp_c_q     <= 5'd0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
`ifdef ALU_ISSUER_RESULT_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sweep_q     <= sweep_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_c_q     <= rsp_c_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
`ifdef ALU_ISSUER_RESULT_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign alu_code  = code_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;
`ifdef ALU_ISSUER_RESULT_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed bench for alu_issuer. A transaction-level model
// (queue of expected responses plus the cycle of the last accept or
// handshake) predicts every output each cycle; directed tests also pin
// hand-computed literal results.
module tb_alu_issuer;

  localparam int SETTLE_CYC = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_code;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_sweep;
  logic [1:0] alu_code;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_code;
  logic [4:0] rsp_c;
  logic       rsp_last;
  logic       busy;
  logic       err;
  logic       fault;

  alu_issuer #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sweep (req_sweep),
    .alu_code  (alu_code),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_code  (rsp_code),
    .rsp_c     (rsp_c),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_fn(input logic [1:0] code, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] ea;
    logic [4:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (code)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return ea - eb;
      default: return ea + eb;
    endcase
  endfunction

  // External ALU, with an optional stuck-at-1 on bit 0.
  always_comb alu_c = alu_fn(alu_code, alu_a, alu_b) | {4'b0000, fault};

  typedef struct {
    logic [1:0] code;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] c;
    logic       last;
    logic       bad;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_evt = 0;
  int   accepts = 0;
  logic rdy_m = 1'b0;
  logic was_rst = 1'b0;
  logic [1:0] got_code[$];
  logic [4:0] got_c[$];
  logic       got_last[$];
  int         got_lat[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got == want) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Model update on each rising edge: handshake pops, accepts push.
  always @(posedge clk) begin
    logic ev;
    ev = (q.size() > 0) && ((cyc - last_evt) >= SETTLE_CYC + 1);
    cyc++;
    if (rst) begin
      q.delete();
      rdy_m   = 1'b0;
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      if (ev && rsp_ready) begin
        got_code.push_back(rsp_code);
        got_c.push_back(rsp_c);
        got_last.push_back(rsp_last);
        void'(q.pop_front());
        last_evt = cyc;
      end else if (rdy_m && req_valid) begin
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          if (req_sweep || k == 0) begin
            e.code = req_sweep ? 2'(k) : req_code;
            e.a    = req_a;
            e.b    = req_b;
            e.c    = alu_fn(e.code, req_a, req_b) | {4'b0000, fault};
            e.last = !req_sweep || (k == 3);
            e.bad  = fault;
            q.push_back(e);
          end
        end
        last_evt = cyc;
        accepts++;
      end
      rdy_m = (q.size() == 0);
    end
  end

  // Compare process: every output checked against the model each cycle.
  logic model_err = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic ev;
    if (was_rst) begin
      model_err = 1'b0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_code",  rsp_code,  0);
      chk("rst_rsp_c",     rsp_c,     0);
      chk("rst_rsp_last",  rsp_last,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_err",       err,       0);
      chk("rst_alu_code",  alu_code,  0);
      chk("rst_alu_a",     alu_a,     0);
      chk("rst_alu_b",     alu_b,     0);
    end else begin
      ev = (q.size() > 0) && ((cyc - last_evt) >= SETTLE_CYC + 1);
      chk("rsp_valid", rsp_valid, ev);
      chk("busy", busy, q.size() > 0);
      chk("req_ready", req_ready, rdy_m);
      if (q.size() > 0) begin
        chk("alu_code", alu_code, q[0].code);
        chk("alu_a", alu_a, q[0].a);
        chk("alu_b", alu_b, q[0].b);
      end
      if (ev) begin
`ifdef ALU_ISSUER_RESULT_CHECK_EN
        if (q[0].bad) model_err = 1'b1;
`endif
        chk("rsp_code", rsp_code, q[0].code);
        chk("rsp_c", rsp_c, q[0].c);
        chk("rsp_last", rsp_last, q[0].last);
      end
      chk("err", err, model_err);
      if (rsp_valid && !prev_valid) got_lat.push_back(cyc - last_evt);
    end
    prev_valid = rsp_valid;
  end

  task automatic send(input logic [1:0] code, input logic [3:0] a, input logic [3:0] b, input logic sweep);
    int n;
    bit ok;
    n = accepts;
    ok = 1'b0;
    req_code  = code;
    req_a     = a;
    req_b     = b;
    req_sweep = sweep;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (accepts != n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int count, input int hold, input bit pulse);
    bit ok;
    for (int r = 0; r < count; r++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (rsp_valid) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) chk("rsp_timeout", 0, 1);
      for (int h = 0; h < hold; h++) begin
        req_valid = pulse && (h == 1);
        req_code  = 2'b11;
        req_a     = 4'h7;
        req_b     = 4'h7;
        req_sweep = 1'b0;
        @(posedge clk);
        #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  int base;
  int lb;

  initial begin
    logic [4:0] sw_c [4];
    sw_c[0] = 5'h08; sw_c[1] = 5'h0E; sw_c[2] = 5'h02; sw_c[3] = 5'h16;
    rst = 1'b1; req_valid = 1'b0; req_code = 2'b00; req_a = 4'h0; req_b = 4'h0;
    req_sweep = 1'b0; rsp_ready = 1'b0; fault = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", req_ready, 1);

    // ADD 9+8, latency 2 cycles
    base = got_c.size(); lb = got_lat.size();
    send(2'b11, 4'h9, 4'h8, 1'b0);
    drain(1, 0, 1'b0);
    chk("add_c", got_c[base], 5'h11);
    chk("add_code", got_code[base], 2'b11);
    chk("add_last", got_last[base], 1);
    chk("add_latency", got_lat[lb], 2);

    // Sweep on C/A; req_code is ignored
    base = got_c.size();
    send(2'b10, 4'hC, 4'hA, 1'b1);
    drain(4, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("sweep_code", got_code[base + k], k);
      chk("sweep_c", got_c[base + k], sw_c[k]);
      chk("sweep_last", got_last[base + k], (k == 3) ? 1 : 0);
    end

    // SUB wrap 3-5
    base = got_c.size();
    send(2'b10, 4'h3, 4'h5, 1'b0);
    drain(1, 0, 1'b0);
    chk("sub_wrap_c", got_c[base], 5'h1E);

    // Backpressure 5 cycles with an ignored request pulse
    base = got_c.size();
    send(2'b01, 4'h5, 4'hA, 1'b0);
    drain(1, 5, 1'b1);
    chk("bp_or_c", got_c[base], 5'h0F);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra_rsp", got_c.size(), base + 1);

    // AND and ADD with carry out
    base = got_c.size();
    send(2'b00, 4'hF, 4'h3, 1'b0);
    drain(1, 0, 1'b0);
    send(2'b11, 4'hF, 4'hF, 1'b0);
    drain(1, 2, 1'b0);
    chk("and_c", got_c[base], 5'h03);
    chk("add_carry_c", got_c[base + 1], 5'h1E);

    // Reset mid-SETTLE of a sweep
    base = got_c.size();
    send(2'b00, 4'h6, 4'h3, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("rst_no_rsp", got_c.size(), base);
    send(2'b11, 4'h1, 4'h2, 1'b0);
    drain(1, 0, 1'b0);
    chk("post_rst_c", got_c[base], 5'h03);
    chk("post_rst_last", got_last[base], 1);

`ifdef ALU_ISSUER_RESULT_CHECK_EN
    fault = 1'b1;
    send(2'b00, 4'h0, 4'h0, 1'b0);
    drain(1, 0, 1'b0);
    chk("err_set", err, 1);
    fault = 1'b0;
    send(2'b11, 4'h2, 4'h2, 1'b0);
    drain(1, 0, 1'b0);
    chk("err_sticky", err, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("err_cleared", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
